// File: rtl/fnd_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// fnd_scan_controller_pkg : shared 7-segment fonts, digit enables, scan rates
// Revision: 1.0
// ============================================================================
package fnd_scan_controller_pkg;

   localparam int DEF_CLK_HZ  = 100_000_000;
   localparam int DEF_SCAN_HZ = 1000;

   // Active-low segments, [6:0] = g..a, [7] = dp (left dark here)
   localparam logic [7:0] FONT_0     = 8'hC0;
   localparam logic [7:0] FONT_1     = 8'hF9;
   localparam logic [7:0] FONT_2     = 8'hA4;
   localparam logic [7:0] FONT_3     = 8'hB0;
   localparam logic [7:0] FONT_4     = 8'h99;
   localparam logic [7:0] FONT_5     = 8'h92;
   localparam logic [7:0] FONT_6     = 8'h82;
   localparam logic [7:0] FONT_7     = 8'hF8;
   localparam logic [7:0] FONT_8     = 8'h80;
   localparam logic [7:0] FONT_9     = 8'h90;
   localparam logic [7:0] FONT_BLANK = 8'hFF;

   localparam logic [3:0] DIGIT_EN_0 = 4'b1110;
   localparam logic [3:0] DIGIT_EN_1 = 4'b1101;
   localparam logic [3:0] DIGIT_EN_2 = 4'b1011;
   localparam logic [3:0] DIGIT_EN_3 = 4'b0111;
   localparam logic [3:0] DIGIT_OFF  = 4'b1111;

   function automatic logic [3:0] digit_enable(input logic [1:0] idx);
      case (idx)
         2'd0:    return DIGIT_EN_0;
         2'd1:    return DIGIT_EN_1;
         2'd2:    return DIGIT_EN_2;
         default: return DIGIT_EN_3;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_scan_controller_bcd_to_fnd.sv
`default_nettype none
// ============================================================================
// bcd_to_fnd : combinational BCD + decimal point to active-low 7-seg font
// Revision: 1.0
// ============================================================================
module bcd_to_fnd
   import fnd_scan_controller_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp,
   output logic [7:0] font
);

   logic [7:0] seg;

   always_comb begin
      seg = FONT_BLANK;
      case (bcd)
         4'd0:    seg = FONT_0;
         4'd1:    seg = FONT_1;
         4'd2:    seg = FONT_2;
         4'd3:    seg = FONT_3;
         4'd4:    seg = FONT_4;
         4'd5:    seg = FONT_5;
         4'd6:    seg = FONT_6;
         4'd7:    seg = FONT_7;
         4'd8:    seg = FONT_8;
         4'd9:    seg = FONT_9;
         default: seg = FONT_BLANK;
      endcase
   end

   // Non-decimal codes stay blank but still honour the decimal point
   assign font = {seg[7] & ~dp, seg[6:0]};

endmodule
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// fnd_scan_controller : 4-digit multiplexed 7-segment scanner with frame-
//                       synchronous shadow capture, blanking and dimming
// Revision: 1.0
// ============================================================================
module fnd_scan_controller
   import fnd_scan_controller_pkg::*;
#(
   parameter int CLK_HZ  = DEF_CLK_HZ,
   parameter int SCAN_HZ = DEF_SCAN_HZ
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pwswitch,
   input  logic [15:0] i_digit_data,
   input  logic [3:0]  i_dp_mask,
   input  logic        i_dim,
   output logic [2:0]  o_select,
   output logic [3:0]  o_digitposition,
   output logic [7:0]  o_font,
   output logic        o_frame_tick
);

   localparam int PRESCALE = CLK_HZ / SCAN_HZ;
   localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] prescale_cnt;
   logic [15:0]     shadow_data;
   logic [3:0]      shadow_dp;
   logic            tick;
   logic            wrap;
   logic [3:0]      cur_nibble;
   logic            cur_dp;
   logic [7:0]      cur_font;

   assign tick       = (prescale_cnt == PS_W'(PRESCALE - 1));
   assign wrap       = tick && (o_select == 3'd7);
   assign cur_nibble = shadow_data[{o_select[1:0], 2'b00} +: 4];
   assign cur_dp     = shadow_dp[o_select[1:0]];

   bcd_to_fnd u_bcd_to_fnd (
      .bcd  (cur_nibble),
      .dp   (cur_dp),
      .font (cur_font)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         prescale_cnt    <= '0;
         o_select        <= 3'd0;
         shadow_data     <= 16'h0000;
         shadow_dp       <= 4'b0000;
         o_frame_tick    <= 1'b0;
         o_digitposition <= DIGIT_OFF;
         o_font          <= FONT_BLANK;
      end else begin
         prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
         o_frame_tick <= wrap;
         if (tick) begin
            o_select <= o_select + 3'd1;
         end
         // Shadow loads only at the frame boundary so a frame never tears
         if (wrap) begin
            shadow_data <= i_digit_data;
            shadow_dp   <= i_dp_mask;
         end
         if (i_pwswitch) begin
            o_digitposition <= DIGIT_OFF;
            o_font          <= FONT_BLANK;
         end else begin
            o_digitposition <= (i_dim && o_select[2]) ? DIGIT_OFF
                                                      : digit_enable(o_select[1:0]);
            o_font          <= cur_font;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_fnd_scan_controller : directed vector bench, PRESCALE = 4
// Revision: 1.0
// ============================================================================
module tb_fnd_scan_controller;

   logic        clk;
   logic        rst;
   logic        pwswitch;
   logic [15:0] digit_data;
   logic [3:0]  dp_mask;
   logic        dim;
   logic [2:0]  sel;
   logic [3:0]  digpos;
   logic [7:0]  font;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   fnd_scan_controller #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_pwswitch      (pwswitch),
      .i_digit_data    (digit_data),
      .i_dp_mask       (dp_mask),
      .i_dim           (dim),
      .o_select        (sel),
      .o_digitposition (digpos),
      .o_font          (font),
      .o_frame_tick    (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp;
      logic        dim;
      logic        pw;
      logic [2:0]  sel;
      logic [3:0]  pos;
      logic [7:0]  font;
   } vec_t;

   localparam int NV = 33;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " select"}, 16'(sel), 16'd0);
      chk({tag, " digpos"}, 16'(digpos), 16'hF);
      chk({tag, " font"}, 16'(font), 16'hFF);
      chk({tag, " frame_tick"}, 16'(frame_tick), 16'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // One entry per scan step: inputs applied, then sampled mid-step
      vecs[0]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd1, 4'b1101, 8'hC0};
      vecs[1]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd2, 4'b1011, 8'hC0};
      vecs[2]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd3, 4'b0111, 8'hC0};
      vecs[3]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd4, 4'b1110, 8'hC0};
      vecs[4]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd5, 4'b1101, 8'hC0};
      vecs[5]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd6, 4'b1011, 8'hC0};
      vecs[6]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd7, 4'b0111, 8'hC0};
      vecs[7]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd0, 4'b1110, 8'h99};
      vecs[8]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd1, 4'b1101, 8'hB0};
      vecs[9]  = '{16'h1234, 4'h0, 1'b0, 1'b0, 3'd2, 4'b1011, 8'hA4};
      vecs[10] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd3, 4'b0111, 8'hF9};
      vecs[11] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd4, 4'b1110, 8'h99};
      vecs[12] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd5, 4'b1101, 8'hB0};
      vecs[13] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd6, 4'b1011, 8'hA4};
      vecs[14] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd7, 4'b0111, 8'hF9};
      vecs[15] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd0, 4'b1110, 8'h80};
      vecs[16] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd1, 4'b1101, 8'hF8};
      vecs[17] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd2, 4'b1011, 8'h82};
      vecs[18] = '{16'h5678, 4'h0, 1'b0, 1'b0, 3'd3, 4'b0111, 8'h92};
      vecs[19] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd4, 4'b1111, 8'h80};
      vecs[20] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd5, 4'b1111, 8'hF8};
      vecs[21] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd6, 4'b1111, 8'h82};
      vecs[22] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd7, 4'b1111, 8'h92};
      vecs[23] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd0, 4'b1110, 8'hFF};
      vecs[24] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd1, 4'b1101, 8'h40};
      vecs[25] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd2, 4'b1011, 8'hFF};
      vecs[26] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd3, 4'b0111, 8'hFF};
      vecs[27] = '{16'hFA0F, 4'h2, 1'b1, 1'b0, 3'd4, 4'b1111, 8'hFF};
      vecs[28] = '{16'hFA0F, 4'h2, 1'b1, 1'b1, 3'd5, 4'b1111, 8'hFF};
      vecs[29] = '{16'hFA0F, 4'h2, 1'b0, 1'b1, 3'd6, 4'b1111, 8'hFF};
      vecs[30] = '{16'hFA0F, 4'h2, 1'b0, 1'b0, 3'd7, 4'b0111, 8'hFF};
      vecs[31] = '{16'hFA0F, 4'h2, 1'b0, 1'b0, 3'd0, 4'b1110, 8'hFF};
      vecs[32] = '{16'hFA0F, 4'h2, 1'b0, 1'b0, 3'd1, 4'b1101, 8'h40};

      rst        = 1'b1;
      pwswitch   = 1'b0;
      digit_data = 16'h1234;
      dp_mask    = 4'h0;
      dim        = 1'b0;
      #1;
      chk_reset_vals("reset");

      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("start select", 16'(sel), 16'd0);
      chk("start digpos", 16'(digpos), 16'hE);
      chk("start font", 16'(font), 16'hC0);
      chk("start frame_tick", 16'(frame_tick), 16'd0);

      for (int j = 0; j < NV; j++) begin
         digit_data = vecs[j].data;
         dp_mask    = vecs[j].dp;
         dim        = vecs[j].dim;
         pwswitch   = vecs[j].pw;
         if (j == 0) begin
            repeat (2) @(negedge clk);
            chk("lag select", 16'(sel), 16'd1);
            chk("lag digpos", 16'(digpos), 16'hE);
            repeat (2) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         chk($sformatf("vec%0d select", j), 16'(sel), 16'(vecs[j].sel));
         chk($sformatf("vec%0d digpos", j), 16'(digpos), 16'(vecs[j].pos));
         chk($sformatf("vec%0d font", j), 16'(font), 16'(vecs[j].font));
      end

      // Power switch held for 10 clocks starting at select 1
      pwswitch = 1'b1;
      #1;
      chk("pw same-cycle digpos", 16'(digpos), 16'hD);
      @(negedge clk);
      chk("pw digpos", 16'(digpos), 16'hF);
      chk("pw font", 16'(font), 16'hFF);
      repeat (9) @(negedge clk);
      chk("pw select steps", 16'(sel), 16'd4);
      chk("pw held digpos", 16'(digpos), 16'hF);
      pwswitch = 1'b0;
      @(negedge clk);
      chk("pw release digpos", 16'(digpos), 16'hE);
      chk("pw release font", 16'(font), 16'hFF);

      // Asynchronous reset in the middle of select 5
      repeat (4) @(negedge clk);
      chk("pre-rst select", 16'(sel), 16'd5);
      chk("pre-rst digpos", 16'(digpos), 16'hD);
      chk("pre-rst font", 16'(font), 16'h40);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("async rst");
      @(negedge clk);
      rst        = 1'b0;
      digit_data = 16'h5678;
      dp_mask    = 4'h0;
      @(negedge clk);
      chk("post-rst digpos", 16'(digpos), 16'hE);
      chk("post-rst font zero", 16'(font), 16'hC0);
      repeat (2) @(negedge clk);
      chk("post-rst hold select", 16'(sel), 16'd0);
      @(negedge clk);
      chk("post-rst first step", 16'(sel), 16'd1);

      // First wrap after reset: frame tick and first capture
      repeat (27) @(negedge clk);
      chk("pre-wrap select", 16'(sel), 16'd7);
      chk("pre-wrap frame_tick", 16'(frame_tick), 16'd0);
      chk("pre-wrap digpos", 16'(digpos), 16'h7);
      chk("pre-wrap font", 16'(font), 16'hC0);
      @(negedge clk);
      chk("wrap select", 16'(sel), 16'd0);
      chk("wrap frame_tick", 16'(frame_tick), 16'd1);
      @(negedge clk);
      chk("post-wrap frame_tick", 16'(frame_tick), 16'd0);
      chk("post-wrap digpos", 16'(digpos), 16'hE);
      chk("post-wrap font", 16'(font), 16'h80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
